// File: rtl/ddr3_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_pkg
// Shared constants and types for the DDR3 controller user-side logic.
//   - Controller FSM state codes that correspond to command acceptance.
//   - Address/data widths for the 2GB x16 part.
//   - State encoding for the request arbiter.
// ---------------------------------------------------------------------------
package ddr3_pkg;

    // Controller states in which a user command has been taken
    localparam int STATE_WRITE_DATA      = 8;
    localparam int STATE_READ_DATA       = 11;

    // 2GB x16 device geometry
    localparam int BANK_ADDRESS_BITWIDTH = 3;
    localparam int ADDRESS_BITWIDTH      = 14;
    localparam int DQ_BITWIDTH           = 16;

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_tag_fifo
// Small synchronous FIFO holding the requester index of every read that the
// controller has accepted, so returned data can be steered in order.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i  enqueue a tag (ignored when full unless popping)
//   pop_i           dequeue the head tag (ignored when empty)
//   head_o          tag at the head of the FIFO
//   full_o/empty_o  occupancy flags
//   count_o         occupancy, clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module ddr3_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only safe when the head leaves this cycle
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers are PTR_W bits wide, so they wrap mod DEPTH on their own
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_request_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_request_arbiter
// Shares the single user port of the DDR3 controller between NUM_REQ
// requesters. Round-robin grant, command held until the controller accepts
// it, read data steered back to the issuing requester via a tag FIFO.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_write          per-requester command valid / 1=write
//   req_address/req_wdata        packed per-requester payload (slice i)
//   req_ready                    one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_data           one-hot read return strobe, shared data
//   write_enable/read_enable     command strobes to the controller
//   i_user_data_address/data_to_ram  command payload to the controller
//   ctrl_cmd_accept              controller took the current command
//   ctrl_rd_valid/data_from_ram  controller read return
//   busy                         issuing or reads outstanding
//   timeout_err/tag_err          sticky error flags
// ---------------------------------------------------------------------------
module ddr3_request_arbiter
    import ddr3_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_BITWIDTH  = ddr3_pkg::BANK_ADDRESS_BITWIDTH + ddr3_pkg::ADDRESS_BITWIDTH,
    parameter int DQ_BITWIDTH    = ddr3_pkg::DQ_BITWIDTH,
    parameter int TAG_FIFO_DEPTH = 4,
    parameter int ISSUE_TIMEOUT  = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_BITWIDTH-1:0]  req_address,
    input  logic [NUM_REQ*DQ_BITWIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DQ_BITWIDTH-1:0]            rsp_data,
    output logic                              write_enable,
    output logic                              read_enable,
    output logic [ADDR_BITWIDTH-1:0]          i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]            data_to_ram,
    input  logic                              ctrl_cmd_accept,
    input  logic                              ctrl_rd_valid,
    input  logic [DQ_BITWIDTH-1:0]            data_from_ram,
    output logic                              busy,
    output logic                              timeout_err,
    output logic                              tag_err
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(ISSUE_TIMEOUT + 1);
    localparam int CNT_W = $clog2(TAG_FIFO_DEPTH) + 1;
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(ISSUE_TIMEOUT);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(NUM_REQ - 1);

    arb_state_t                 state_q, state_d;
    logic [TAG_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]           grant_q, grant_d;
    logic                       cmd_write_q, cmd_write_d;
    logic [ADDR_BITWIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DQ_BITWIDTH-1:0]     cmd_wdata_q, cmd_wdata_d;
    logic [WD_W-1:0]            wd_cnt_q, wd_cnt_d;
    logic                       timeout_err_q, timeout_err_d;
    logic                       tag_err_q, tag_err_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DQ_BITWIDTH-1:0]     rsp_data_q, rsp_data_d;

    logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TAG_W-1:0]           fifo_head;
    logic [CNT_W-1:0]           fifo_count;

    logic [ADDR_BITWIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DQ_BITWIDTH-1:0]     wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]         eligible;
    logic                       win_found;
    logic [TAG_W-1:0]           win_idx;
    int                         cand;

    // Unpack payloads; a read can only be granted if its tag has a slot
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr_arr[gi]  = req_address[gi*ADDR_BITWIDTH +: ADDR_BITWIDTH];
        assign wdata_arr[gi] = req_wdata[gi*DQ_BITWIDTH +: DQ_BITWIDTH];
        assign eligible[gi]  = req_valid[gi] & (req_write[gi] | ~fifo_full);
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(cand);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        tag_err_d     = tag_err_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        req_ready     = '0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;

        case (state_q)
            ARB: begin
                wd_cnt_d = '0;
                if (win_found) begin
                    grant_d     = win_idx;
                    cmd_write_d = req_write[win_idx];
                    cmd_addr_d  = addr_arr[win_idx];
                    cmd_wdata_d = wdata_arr[win_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Watchdog only flags; the command keeps being presented
                if (wd_cnt_q == WD_MAX) begin
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                if (ctrl_cmd_accept) begin
                    req_ready[grant_q] = 1'b1;
                    fifo_push          = ~cmd_write_q;
                    rr_ptr_d           = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                    wd_cnt_d           = '0;
                    state_d            = ARB;
                end
            end
            default: state_d = ARB;
        endcase

        if (ctrl_rd_valid) begin
            if (fifo_empty) begin
                tag_err_d = 1'b1;
            end else begin
                fifo_pop               = 1'b1;
                rsp_valid_d[fifo_head] = 1'b1;
                rsp_data_d             = data_from_ram;
            end
        end

        // An accept coinciding with reset is discarded along with the command
        if (reset) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            tag_err_q     <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            tag_err_q     <= tag_err_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    ddr3_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (grant_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign write_enable        = (state_q == ISSUE) &  cmd_write_q;
    assign read_enable         = (state_q == ISSUE) & ~cmd_write_q;
    assign i_user_data_address = cmd_addr_q;
    assign data_to_ram         = cmd_wdata_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_data            = rsp_data_q;
    assign busy                = (state_q != ARB) | (fifo_count != '0);
    assign timeout_err         = timeout_err_q;
    assign tag_err             = tag_err_q;

endmodule

// File: tb/tb_ddr3_request_arbiter.sv
module tb_ddr3_request_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 17;
    localparam int DW      = 16;
    localparam int DEPTH   = 4;
    localparam int TMO     = 4096;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_address;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  write_enable;
    logic                  read_enable;
    logic [AW-1:0]         i_user_data_address;
    logic [DW-1:0]         data_to_ram;
    logic                  ctrl_cmd_accept;
    logic                  ctrl_rd_valid;
    logic [DW-1:0]         data_from_ram;
    logic                  busy;
    logic                  timeout_err;
    logic                  tag_err;

    always #5 clk = ~clk;

    ddr3_request_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_BITWIDTH  (AW),
        .DQ_BITWIDTH    (DW),
        .TAG_FIFO_DEPTH (DEPTH),
        .ISSUE_TIMEOUT  (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_write           (req_write),
        .req_address         (req_address),
        .req_wdata           (req_wdata),
        .req_ready           (req_ready),
        .rsp_valid           (rsp_valid),
        .rsp_data            (rsp_data),
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .i_user_data_address (i_user_data_address),
        .data_to_ram         (data_to_ram),
        .ctrl_cmd_accept     (ctrl_cmd_accept),
        .ctrl_rd_valid       (ctrl_rd_valid),
        .data_from_ram       (data_from_ram),
        .busy                (busy),
        .timeout_err         (timeout_err),
        .tag_err             (tag_err)
    );

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every grant and every read return is matched
    // against the oldest expectation pushed by the stimulus.
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (req_ready != '0) begin
            if (exp_cmd.size() == 0) begin
                check("unexpected_req_ready", 32'(req_ready), 32'h0);
            end else begin
                c = exp_cmd.pop_front();
                check("grant_onehot", 32'(req_ready), 32'(1) << c.idx);
                check("grant_we", 32'(write_enable), 32'(c.wr));
                check("grant_re", 32'(read_enable), 32'(!c.wr));
                check("grant_addr", 32'(i_user_data_address), c.addr);
                if (c.wr) check("grant_wdata", 32'(data_to_ram), c.data);
                $display("cmd  req=%0d wr=%0d addr=%05h data=%04h", c.idx, c.wr, i_user_data_address, data_to_ram);
            end
        end
        if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_onehot", 32'(rsp_valid), 32'(1) << r.idx);
                check("rsp_data", 32'(rsp_data), r.data);
                $display("rsp  req=%0d data=%04h", r.idx, rsp_data);
            end
        end
    end

    task automatic set_req(input int i, input bit v, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = wr;
        req_address[i*AW +: AW] = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic expect_cmd(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.idx = i; c.wr = wr; c.addr = a; c.data = d;
        exp_cmd.push_back(c);
    endtask

    task automatic expect_rsp(input int i, input logic [31:0] d);
        rsp_t r;
        r.idx = i; r.data = d;
        exp_rsp.push_back(r);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0;
        ctrl_cmd_accept = 1'b0; ctrl_rd_valid = 1'b0; data_from_ram = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first ISSUE cycle
    task automatic wait_issue();
        int n = 0;
        while (!(write_enable || read_enable) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("wait_issue_timeout", 32'(n), 32'h0);
    endtask

    task automatic accept_now();
        ctrl_cmd_accept = 1'b1;
        @(posedge clk); #1;
        ctrl_cmd_accept = 1'b0;
    endtask

    task automatic rd_pulse(input logic [DW-1:0] d);
        ctrl_rd_valid = 1'b1;
        data_from_ram = d;
        @(posedge clk); #1;
        ctrl_rd_valid = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        apply_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_enables", 32'({write_enable, read_enable}), 32'h0);
        check("rst_addr", 32'(i_user_data_address), 32'h0);
        check("rst_flags", 32'({busy, timeout_err, tag_err}), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // ---- single write, accept in the 5th ISSUE cycle ----
        apply_reset();
        expect_cmd(0, 1'b1, 32'h00010, 32'hA5A5);
        set_req(0, 1'b1, 1'b1, 17'h00010, 16'hA5A5);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_hold_we", 32'(write_enable), 32'h1);
            check("t1_hold_addr", 32'(i_user_data_address), 32'h00010);
            check("t1_hold_data", 32'(data_to_ram), 32'hA5A5);
            check("t1_no_early_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1;
        ctrl_cmd_accept = 1'b1;
        @(negedge clk);
        check("t1_we_at_accept", 32'(write_enable), 32'h1);
        @(posedge clk); #1;
        ctrl_cmd_accept = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t1_we_dropped", 32'({write_enable, read_enable}), 32'h0);
        check("t1_busy_idle", 32'(busy), 32'h0);

        // ---- contention: alternating grants, immediate accept ----
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) expect_cmd(0, 1'b1, 32'h00100, 32'h0101);
            else            expect_cmd(1, 1'b1, 32'h00200, 32'h0202);
        end
        set_req(0, 1'b1, 1'b1, 17'h00100, 16'h0101);
        set_req(1, 1'b1, 1'b1, 17'h00200, 16'h0202);
        for (int k = 0; k < 6; k++) begin
            wait_issue();
            accept_now();
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("t2_all_granted", 32'(exp_cmd.size()), 32'h0);

        // ---- read tagging ----
        apply_reset();
        expect_cmd(1, 1'b0, 32'h00300, 32'h0);
        set_req(1, 1'b1, 1'b0, 17'h00300, '0);
        wait_issue();
        repeat (2) begin @(posedge clk); #1; end
        accept_now();
        set_req(1, 1'b0, 1'b0, '0, '0);
        expect_cmd(0, 1'b0, 32'h00400, 32'h0);
        set_req(0, 1'b1, 1'b0, 17'h00400, '0);
        wait_issue();
        accept_now();
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t3_busy_outstanding", 32'(busy), 32'h1);
        expect_rsp(1, 32'h1111);
        expect_rsp(0, 32'h2222);
        @(posedge clk); #1;
        rd_pulse(16'h1111);
        rd_pulse(16'h2222);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_busy_drained", 32'(busy), 32'h0);
        check("t3_rsp_all", 32'(exp_rsp.size()), 32'h0);

        // ---- FIFO full, simultaneous push/pop, empty-pop tag_err ----
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            expect_cmd(k % 2, 1'b0, 32'h00500 + 32'(k), 32'h0);
            set_req(k % 2, 1'b1, 1'b0, 17'h00500 + 17'(k), '0);
            wait_issue();
            accept_now();
            set_req(k % 2, 1'b0, 1'b0, '0, '0);
        end
        set_req(0, 1'b1, 1'b0, 17'h00600, '0);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t4_full_read_blocked", 32'({write_enable, read_enable}), 32'h0);
        @(posedge clk); #1;
        expect_cmd(1, 1'b1, 32'h00700, 32'hBEEF);
        set_req(1, 1'b1, 1'b1, 17'h00700, 16'hBEEF);
        wait_issue();
        accept_now();
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t4_full_read_still_blocked", 32'({write_enable, read_enable}), 32'h0);
        @(posedge clk); #1;
        expect_cmd(0, 1'b0, 32'h00600, 32'h0);
        expect_rsp(0, 32'hD000);
        rd_pulse(16'hD000);
        wait_issue();
        expect_rsp(1, 32'hD001);
        ctrl_cmd_accept = 1'b1;
        ctrl_rd_valid   = 1'b1;
        data_from_ram   = 16'hD001;
        @(posedge clk); #1;
        ctrl_cmd_accept = 1'b0;
        ctrl_rd_valid   = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        // Three tags must remain: 0, 1, 0
        expect_rsp(0, 32'hD002);
        expect_rsp(1, 32'hD003);
        expect_rsp(0, 32'hD004);
        rd_pulse(16'hD002);
        rd_pulse(16'hD003);
        rd_pulse(16'hD004);
        @(negedge clk);
        check("t4_no_tag_err_yet", 32'(tag_err), 32'h0);
        @(posedge clk); #1;
        rd_pulse(16'hDEAD);
        @(negedge clk);
        check("t4_tag_err", 32'(tag_err), 32'h1);
        check("t4_tag_err_no_rsp", 32'(rsp_valid), 32'h0);
        check("t4_cmds_done", 32'(exp_cmd.size()), 32'h0);
        check("t4_rsps_done", 32'(exp_rsp.size()), 32'h0);

        // ---- watchdog ----
        apply_reset();
        expect_cmd(0, 1'b1, 32'h00123, 32'h4567);
        set_req(0, 1'b1, 1'b1, 17'h00123, 16'h4567);
        wait_issue();
        repeat (4000) @(posedge clk);
        @(negedge clk);
        check("t5_no_timeout_early", 32'(timeout_err), 32'h0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("t5_timeout_err", 32'(timeout_err), 32'h1);
        check("t5_we_still_high", 32'(write_enable), 32'h1);
        check("t5_addr_held", 32'(i_user_data_address), 32'h00123);
        @(posedge clk); #1;
        accept_now();
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t5_timeout_sticky", 32'(timeout_err), 32'h1);

        // ---- reset in the middle of ISSUE with reads outstanding ----
        apply_reset();
        expect_cmd(0, 1'b0, 32'h00800, 32'h0);
        set_req(0, 1'b1, 1'b0, 17'h00800, '0);
        wait_issue();
        accept_now();
        set_req(0, 1'b0, 1'b0, '0, '0);
        expect_cmd(1, 1'b0, 32'h00801, 32'h0);
        set_req(1, 1'b1, 1'b0, 17'h00801, '0);
        wait_issue();
        accept_now();
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(0, 1'b1, 1'b0, 17'h00802, '0);
        wait_issue();
        reset = 1'b1;
        ctrl_cmd_accept = 1'b1;
        @(negedge clk);
        check("t6_no_ready_in_reset", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        ctrl_cmd_accept = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t6_enables_dropped", 32'({write_enable, read_enable}), 32'h0);
        check("t6_busy_clear", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rd_pulse(16'h7777);
        @(negedge clk);
        check("t6_fifo_emptied", 32'(tag_err), 32'h1);
        check("t6_no_rsp", 32'(rsp_valid), 32'h0);
        check("t6_cmds_done", 32'(exp_cmd.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
